leitor_display: RTL and testbench
=================================

# leitor_display

Sequential 7-segment-to-BCD reader for the timer's three-digit display (minutes, tens of seconds, seconds). It samples the three 7-segment buses, waits until the pattern has been stable for a set number of cycles, and decodes each digit back to BCD. It also computes the total count in seconds and reports invalid patterns. Each new stable value is delivered once over a valid/ready handshake to the self-check/monitor logic of the timer project.

## Interface
- STABLE_CYCLES, 4: consecutive equal samples required before a pattern is accepted; minimum 1.
- MAX_DEZENA, 5: largest legal tens-of-seconds digit.
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- InMinutos  input  7  minutes segments; bit6=a … bit0=g, active-high.
- InDezena  input  7  tens-of-seconds segments, same encoding.
- InSegundos  input  7  seconds segments, same encoding.
- Minutos  output  4  decoded minutes BCD; 4'hF if the pattern is invalid.
- DezenaSeg  output  4  decoded tens-of-seconds BCD; 4'hF if the pattern is invalid.
- Segundos  output  4  decoded seconds BCD; 4'hF if the pattern is invalid.
- TotalSeg  output  10  Minutos*60 + DezenaSeg*10 + Segundos; 0 when out_err=1.
- out_err  output  1  any digit invalid, or DezenaSeg > MAX_DEZENA.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.

## Operation
- Legal codes:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Any other 7-bit value, including blank 0000000, is invalid and decodes to 4'hF.
- Stability filter, evaluated every edge on the concatenated 21-bit input:
  - If input == sample_q, then stab_cnt <= min(stab_cnt+1, STABLE_CYCLES); otherwise stab_cnt <= 0.
  - sample_q <= input on every edge.
- State SETTLE:
  - The block emits when stab_cnt == STABLE_CYCLES and either first_flag=1 or sample_q != last_q.
  - On emission: latch the decoded outputs, TotalSeg and out_err; set last_q <= sample_q; clear first_flag; set out_valid <= 1; go to PRESENT.
- State PRESENT:
  - All outputs hold.
  - On out_valid && out_ready: out_valid <= 0 and the state returns to SETTLE.
  - Input changes during PRESENT do not alter the outputs. The filter keeps running, so a value that has already settled can be emitted on the first SETTLE cycle.
- Emit-on-change: a stable pattern equal to last_q is never re-emitted.
- Arithmetic:
  - TotalSeg is computed in 10 bits; the maximum legal value is 9*60+59 = 599.
  - When out_err=1, TotalSeg = 0, and Minutos, DezenaSeg and Segundos still show the per-digit decode (4'hF where invalid).
  - If DezenaSeg > MAX_DEZENA but every digit is valid: out_err=1 and the digits are shown as decoded.

## Timing
- Reset (rst_n=0 at an edge):
  - State SETTLE; stab_cnt=0; sample_q=0; last_q=0; first_flag=1.
  - Minutos, DezenaSeg, Segundos and TotalSeg = 0; out_err=0; out_valid=0.
- Reset during PRESENT drops out_valid on that edge. The pending result is discarded; no handshake is needed.
- Latency: inputs change before edge E1 and are then held. stab_cnt reaches STABLE_CYCLES at edge E(STABLE_CYCLES+1). out_valid is high after edge E(STABLE_CYCLES+2), i.e. after the 6th edge at the default.
- A glitch of any length below the stability window restarts the count. No emission happens for a pattern that does not persist.
- out_ready may be high before out_valid rises. The transfer still occurs at the first edge where both are high, so out_valid lasts at least one cycle.
- After a handshake, the next out_valid rises at the earliest one edge after returning to SETTLE (one idle cycle minimum).
- out_valid, once high, stays high until the handshake or reset; outputs are stable while it is high.

## Structure
- Shared package (display_pkg):
  - SEG_0..SEG_9 pattern constants.
  - BCD_INVALID = 4'hF.
  - The state enum {SETTLE, PRESENT}.
- Sub-module seg_para_bcd: combinational 7-bit to {4-bit BCD, valid}, instantiated three times.
- Top level holds the filter, the FSM, the last_q register and the TotalSeg arithmetic.

## Test plan
- Reset, then hold all inputs = SEG_0 with out_ready=1 -> after the 6th edge: out_valid=1, digits 0/0/0, TotalSeg=0, out_err=0; out_valid drops the next edge and stays low while inputs are held.
- Present 3/4/7 stable with out_ready=0 for 10 cycles -> out_valid=1, TotalSeg=227, held through; out_ready=1 -> accepted in one cycle; no re-emission.
- Change seconds from SEG_7 to SEG_8 for 3 cycles, then back to SEG_7 -> no emission; a later change to SEG_8 held for 4+ cycles -> TotalSeg=228.
- InDezena = 1011111 (6) with other digits valid -> DezenaSeg=6, out_err=1, TotalSeg=0; InSegundos = 0000000 -> Segundos=4'hF, out_err=1.
- Change pattern during PRESENT, then handshake -> first result unchanged; the new value's out_valid rises one edge after the handshake.
- rst_n=0 for one edge while out_valid=1 -> all outputs 0; the same stable pattern is re-emitted after STABLE_CYCLES+2 edges because first_flag=1.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display reader: 7-segment patterns (bit6=a .. bit0=g,
// active-high), the invalid-digit marker, the reader FSM states and the helper that
// turns three BCD digits into a count of seconds.
package display_pkg;

   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1111011;

   localparam logic [3:0] BCD_INVALID = 4'hF;

   typedef enum logic {SETTLE, PRESENT} state_e;

   // Minutes*60 + tens*10 + seconds in 10 bits. Only meaningful for legal digits;
   // callers mask the result when any digit is invalid.
   function automatic logic [9:0] total_seg(input logic [3:0] min_bcd,
                                            input logic [3:0] dez_bcd,
                                            input logic [3:0] seg_bcd);
      logic [9:0] min_part;
      logic [9:0] dez_part;
      min_part = {6'd0, min_bcd} * 10'd60;
      dez_part = {6'd0, dez_bcd} * 10'd10;
      return min_part + dez_part + {6'd0, seg_bcd};
   endfunction

endpackage

// File: rtl/seg_para_bcd.sv
// Combinational 7-segment to BCD decoder.
//   seg_i   : segment pattern, bit6=a .. bit0=g, active-high
//   bcd_o   : decoded digit, BCD_INVALID for any non-digit pattern (including blank)
//   valid_o : 1 when seg_i is one of the ten legal digit patterns
module seg_para_bcd
   import display_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] bcd_o,
   output logic       valid_o
);

   always_comb begin
      bcd_o   = BCD_INVALID;
      valid_o = 1'b0;
      unique case (seg_i)
         SEG_0: begin bcd_o = 4'd0; valid_o = 1'b1; end
         SEG_1: begin bcd_o = 4'd1; valid_o = 1'b1; end
         SEG_2: begin bcd_o = 4'd2; valid_o = 1'b1; end
         SEG_3: begin bcd_o = 4'd3; valid_o = 1'b1; end
         SEG_4: begin bcd_o = 4'd4; valid_o = 1'b1; end
         SEG_5: begin bcd_o = 4'd5; valid_o = 1'b1; end
         SEG_6: begin bcd_o = 4'd6; valid_o = 1'b1; end
         SEG_7: begin bcd_o = 4'd7; valid_o = 1'b1; end
         SEG_8: begin bcd_o = 4'd8; valid_o = 1'b1; end
         SEG_9: begin bcd_o = 4'd9; valid_o = 1'b1; end
         default: begin
            bcd_o   = BCD_INVALID;
            valid_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/leitor_display.sv
// Reads the timer's three 7-segment digits back into BCD.
//   clk, rst_n       : clock and synchronous active-low reset
//   InMinutos        : minutes segments
//   InDezena         : tens-of-seconds segments
//   InSegundos       : seconds segments
//   Minutos/DezenaSeg/Segundos : decoded digits (4'hF where invalid)
//   TotalSeg         : total seconds, 0 when out_err is set
//   out_err          : a digit is invalid or the tens digit exceeds MAX_DEZENA
//   out_valid/out_ready : one-shot handshake per newly settled pattern
// The 21-bit input must repeat for STABLE_CYCLES consecutive edges before it is decoded,
// and a settled pattern is only delivered when it differs from the last delivered one.
module leitor_display
   import display_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned MAX_DEZENA    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] InMinutos,
   input  logic [6:0] InDezena,
   input  logic [6:0] InSegundos,
   output logic [3:0] Minutos,
   output logic [3:0] DezenaSeg,
   output logic [3:0] Segundos,
   output logic [9:0] TotalSeg,
   output logic       out_err,
   output logic       out_valid,
   input  logic       out_ready
);

   localparam int unsigned    CntW   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
   localparam logic [3:0]     DezMax = 4'(MAX_DEZENA);

   logic [20:0]     in_w;
   logic [20:0]     sample_q, sample_d;
   logic [CntW-1:0] stab_cnt_q, stab_cnt_d;
   logic [20:0]     last_q, last_d;
   logic            first_q, first_d;
   state_e          state_q, state_d;

   logic [3:0]      min_q, min_d;
   logic [3:0]      dez_q, dez_d;
   logic [3:0]      seg_q, seg_d;
   logic [9:0]      total_q, total_d;
   logic            err_q, err_d;
   logic            valid_q, valid_d;

   logic [3:0]      min_bcd, dez_bcd, seg_bcd;
   logic            min_ok, dez_ok, seg_ok;
   logic            err_w;
   logic [9:0]      total_w;
   logic            emit_w;

   assign in_w = {InMinutos, InDezena, InSegundos};

   // Decoders look at the registered sample, which is what the stability count refers to.
   seg_para_bcd u_dec_min (
      .seg_i   (sample_q[20:14]),
      .bcd_o   (min_bcd),
      .valid_o (min_ok)
   );

   seg_para_bcd u_dec_dez (
      .seg_i   (sample_q[13:7]),
      .bcd_o   (dez_bcd),
      .valid_o (dez_ok)
   );

   seg_para_bcd u_dec_seg (
      .seg_i   (sample_q[6:0]),
      .bcd_o   (seg_bcd),
      .valid_o (seg_ok)
   );

   always_comb begin
      err_w   = ~(min_ok & dez_ok & seg_ok) | (dez_bcd > DezMax);
      total_w = err_w ? 10'd0 : total_seg(min_bcd, dez_bcd, seg_bcd);
   end

   // Stability filter: runs in every state so a pattern can settle while a result is
   // still waiting for its handshake.
   always_comb begin
      sample_d   = in_w;
      stab_cnt_d = '0;
      if (in_w == sample_q) begin
         stab_cnt_d = (stab_cnt_q == CntMax) ? CntMax : stab_cnt_q + CntW'(1);
      end
   end

   assign emit_w = (stab_cnt_q == CntMax) && (first_q || (sample_q != last_q));

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      first_d = first_q;
      min_d   = min_q;
      dez_d   = dez_q;
      seg_d   = seg_q;
      total_d = total_q;
      err_d   = err_q;
      valid_d = valid_q;
      unique case (state_q)
         SETTLE: begin
            if (emit_w) begin
               min_d   = min_bcd;
               dez_d   = dez_bcd;
               seg_d   = seg_bcd;
               total_d = total_w;
               err_d   = err_w;
               last_d  = sample_q;
               first_d = 1'b0;
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (valid_q && out_ready) begin
               valid_d = 1'b0;
               state_d = SETTLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sample_q   <= '0;
         stab_cnt_q <= '0;
         last_q     <= '0;
         first_q    <= 1'b1;
         state_q    <= SETTLE;
         min_q      <= '0;
         dez_q      <= '0;
         seg_q      <= '0;
         total_q    <= '0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         sample_q   <= sample_d;
         stab_cnt_q <= stab_cnt_d;
         last_q     <= last_d;
         first_q    <= first_d;
         state_q    <= state_d;
         min_q      <= min_d;
         dez_q      <= dez_d;
         seg_q      <= seg_d;
         total_q    <= total_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
      end
   end

   assign Minutos   = min_q;
   assign DezenaSeg = dez_q;
   assign Segundos  = seg_q;
   assign TotalSeg  = total_q;
   assign out_err   = err_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_leitor_display.sv
// Self-checking bench for leitor_display: a window-based behavioural model compared on
// every falling edge, directed scenarios with literal expectations, then random traffic.
module tb_leitor_display;

   localparam int unsigned SC = 4;
   localparam int unsigned MD = 5;
   localparam logic [6:0] CODES [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                         7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                         7'b1111111, 7'b1111011};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] in_min, in_dez, in_seg;
   logic       out_ready;
   logic [3:0] minutos, dezena, segundos;
   logic [9:0] total;
   logic       out_err, out_valid;

   int n_checks = 0;
   int n_errors = 0;

   leitor_display #(
      .STABLE_CYCLES (SC),
      .MAX_DEZENA    (MD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .InMinutos  (in_min),
      .InDezena   (in_dez),
      .InSegundos (in_seg),
      .Minutos    (minutos),
      .DezenaSeg  (dezena),
      .Segundos   (segundos),
      .TotalSeg   (total),
      .out_err    (out_err),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Returns {legal, digit}; digit is 15 for an illegal pattern.
   function automatic logic [4:0] decode(input logic [6:0] p);
      for (int j = 0; j < 10; j++) begin
         if (p == CODES[j]) return {1'b1, 4'(j)};
      end
      return {1'b0, 4'hF};
   endfunction

   // ---------------- behavioural model ----------------
   logic [20:0] hist[$];
   logic        model_ok = 1'b0;
   logic        m_valid, m_first, m_err;
   logic [20:0] m_last;
   logic [3:0]  m_min, m_dez, m_seg;
   logic [9:0]  m_tot;

   // A pattern is accepted once the last SC+1 samples (reset counts as a zero sample)
   // are identical.
   function automatic bit window_stable();
      if (hist.size() != SC + 1) return 1'b0;
      foreach (hist[k]) if (hist[k] != hist[0]) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      logic [20:0] cur;
      logic [4:0]  dm, dd, ds;
      int          tot;
      cur = {in_min, in_dez, in_seg};
      if (!rst_n) begin
         hist.delete();
         hist.push_back(21'd0);
         m_valid = 1'b0; m_first = 1'b1; m_last = '0; m_err = 1'b0;
         m_min = 0; m_dez = 0; m_seg = 0; m_tot = 0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
         end else if (window_stable() && (m_first || hist[$] != m_last)) begin
            dm = decode(hist[$][20:14]);
            dd = decode(hist[$][13:7]);
            ds = decode(hist[$][6:0]);
            m_min = dm[3:0]; m_dez = dd[3:0]; m_seg = ds[3:0];
            m_err = !(dm[4] && dd[4] && ds[4]) || (dd[3:0] > MD);
            tot = 60 * dm[3:0] + 10 * dd[3:0] + ds[3:0];
            m_tot = m_err ? 10'd0 : 10'(tot);
            m_last = hist[$];
            m_first = 1'b0;
            m_valid = 1'b1;
         end
         hist.push_back(cur);
         if (hist.size() > SC + 1) void'(hist.pop_front());
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("out_valid", out_valid, m_valid);
         chk("Minutos", minutos, m_min);
         chk("DezenaSeg", dezena, m_dez);
         chk("Segundos", segundos, m_seg);
         chk("TotalSeg", total, m_tot);
         chk("out_err", out_err, m_err);
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_in(input logic [6:0] m, input logic [6:0] d, input logic [6:0] s);
      in_min = m; in_dez = d; in_seg = s;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [6:0] rand_pat(input bit tens);
      int r;
      r = $urandom_range(0, 19);
      if (r < 16) return tens ? CODES[$urandom_range(0, 6)] : CODES[r % 10];
      if (r == 16) return 7'd0;
      return 7'($urandom);
   endfunction

   initial begin
      rst_n = 1'b0; out_ready = 1'b0;
      set_in(7'd0, 7'd0, 7'd0);
      wait_n(2);
      chk("reset_valid", out_valid, 0);
      chk("reset_total", total, 0);

      // All zeros, ready high: result after the 6th edge, accepted on the next.
      rst_n = 1'b1; out_ready = 1'b1;
      set_in(CODES[0], CODES[0], CODES[0]);
      wait_n(5);
      chk("zero_not_yet", out_valid, 0);
      wait_n(1);
      chk("zero_valid", out_valid, 1);
      chk("zero_total", total, 0);
      chk("zero_err", out_err, 0);
      wait_n(1);
      chk("zero_dropped", out_valid, 0);
      wait_n(5);
      chk("zero_no_reemit", out_valid, 0);

      // 3:47 held while the consumer stalls.
      out_ready = 1'b0;
      set_in(CODES[3], CODES[4], CODES[7]);
      wait_n(10);
      chk("347_valid", out_valid, 1);
      chk("347_total", total, 227);
      chk("347_min", minutos, 3);
      out_ready = 1'b1;
      wait_n(1);
      chk("347_accepted", out_valid, 0);
      wait_n(5);
      chk("347_no_reemit", out_valid, 0);

      // Short glitch on seconds is ignored; a held change is delivered.
      in_seg = CODES[8];
      wait_n(3);
      in_seg = CODES[7];
      wait_n(8);
      chk("glitch_ignored", out_valid, 0);
      out_ready = 1'b0;
      in_seg = CODES[8];
      wait_n(8);
      chk("348_total", total, 228);
      out_ready = 1'b1;
      wait_n(1);

      // Tens digit above the limit, then a blank seconds digit.
      out_ready = 1'b0;
      set_in(CODES[1], CODES[6], CODES[2]);
      wait_n(8);
      chk("dez6_digit", dezena, 6);
      chk("dez6_err", out_err, 1);
      chk("dez6_total", total, 0);
      out_ready = 1'b1;
      wait_n(1);
      out_ready = 1'b0;
      set_in(CODES[1], CODES[2], 7'd0);
      wait_n(8);
      chk("blank_seg", segundos, 4'hF);
      chk("blank_err", out_err, 1);
      out_ready = 1'b1;
      wait_n(1);

      // New pattern settles during PRESENT; delivered one edge after the handshake.
      out_ready = 1'b0;
      set_in(CODES[1], CODES[2], CODES[3]);
      wait_n(8);
      set_in(CODES[2], CODES[3], CODES[4]);
      wait_n(8);
      chk("present_hold", total, 83);
      out_ready = 1'b1;
      wait_n(1);
      chk("handshake_drop", out_valid, 0);
      wait_n(1);
      chk("next_valid", out_valid, 1);
      chk("next_total", total, 154);
      wait_n(1);

      // Reset while presenting, then the same pattern comes back.
      out_ready = 1'b0;
      set_in(CODES[5], CODES[5], CODES[9]);
      wait_n(8);
      chk("pre_reset_valid", out_valid, 1);
      rst_n = 1'b0;
      wait_n(1);
      chk("rst_valid", out_valid, 0);
      chk("rst_total", total, 0);
      chk("rst_min", minutos, 0);
      rst_n = 1'b1;
      wait_n(5);
      chk("rst_not_yet", out_valid, 0);
      wait_n(1);
      chk("rst_reemit", out_valid, 1);
      chk("rst_total_359", total, 359);

      // Random traffic against the model.
      for (int i = 0; i < 500; i++) begin
         set_in(rand_pat(1'b0), rand_pat(1'b1), rand_pat(1'b0));
         if ($urandom_range(0, 3) == 0) begin
            in_seg = rand_pat(1'b0);
         end
         repeat ($urandom_range(1, 9)) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
         end
         rst_n = 1'b1;
      end
      wait_n(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
